// File: rtl/clk_div_pkg.sv
// Shared sizing and types for the programmable clock divider.
// Constants only; no latency, no flow control.
package clk_div_pkg;
    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 32;
    localparam int MAX_CH     = 8;
    localparam int CH_IDX_W   = $clog2(MAX_CH);

    typedef logic [CNT_W_DEF-1:0] div_t;
endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, divide register, registered tick and div_clk (1-cycle latency).
// No backpressure; a config write always lands and outranks the terminal-count event.
module div_channel #(
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             div_clk
);
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] cnt;
    logic             term;

    assign term = (cnt == div_reg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_reg <= DEFAULT_DIV;
            cnt     <= '0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
        end else begin
            // The divide register survives clear, so it is written independently.
            if (wr_en) begin
                div_reg <= wr_div;
            end
            if (clear) begin
                cnt     <= '0;
                tick    <= 1'b0;
                div_clk <= 1'b0;
            end else if (wr_en) begin
                cnt     <= '0;
                tick    <= 1'b0;
            end else if (enable) begin
                if (term) begin
                    cnt     <= '0;
                    tick    <= 1'b1;
                    div_clk <= ~div_clk;
                end else begin
                    cnt     <= cnt + CNT_W'(1);
                    tick    <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/prog_clock_divider.sv
// NUM_CH programmable dividers plus a free-running binary counter; all outputs registered (1 cycle).
// No backpressure; writes to channel indices >= NUM_CH are dropped.
module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter int               NUM_CH      = NUM_CH_DEF,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   div_clk,
    output logic [CNT_W-1:0]    divided_clocks
);
    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic wr_en;
            // Only indices that exist decode, which drops out-of-range writes.
            assign wr_en = cfg_we && (cfg_ch == CH_IDX_W'(i));

            div_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clock   (clock),
                .reset   (reset),
                .enable  (enable),
                .clear   (clear),
                .wr_en   (wr_en),
                .wr_div  (cfg_div),
                .tick    (tick[i]),
                .div_clk (div_clk[i])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divided_clocks <= '0;
        end else if (clear) begin
            divided_clocks <= '0;
        end else if (enable) begin
            divided_clocks <= divided_clocks + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: a cycle model pushes expected outputs per driven cycle,
// each scenario task pops and compares after the edge and adds its own scenario-level checks.
module tb_prog_clock_divider;
    import clk_div_pkg::*;

    localparam int NCH  = NUM_CH_DEF;
    localparam int CW   = CNT_W_DEF;
    localparam div_t DDIV = '0;

    logic            clock = 1'b0;
    logic            reset, enable, clear, cfg_we;
    logic [2:0]      cfg_ch;
    div_t            cfg_div;
    logic [NCH-1:0]  tick, div_clk;
    logic [CW-1:0]   divided_clocks;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] dclk;
        logic [CW-1:0]  free;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_pass = 0;
    int   n_chk  = 0;

    div_t           m_div [NCH];
    div_t           m_cnt [NCH];
    logic [NCH-1:0] m_tick, m_clk;
    logic [CW-1:0]  m_free;

    prog_clock_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .clear          (clear),
        .cfg_we         (cfg_we),
        .cfg_ch         (cfg_ch),
        .cfg_div        (cfg_div),
        .tick           (tick),
        .div_clk        (div_clk),
        .divided_clocks (divided_clocks)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = DDIV;
            m_cnt[i] = '0;
        end
        m_tick = '0;
        m_clk  = '0;
        m_free = '0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        exp_t x;
        logic wr;
        if (!reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < NCH; i++) begin
                wr = cfg_we && (int'(cfg_ch) == i);
                if (clear) begin
                    m_cnt[i] = '0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
                end else if (wr) begin
                    m_cnt[i] = '0; m_tick[i] = 1'b0;
                end else if (enable) begin
                    if (m_cnt[i] == m_div[i]) begin
                        m_cnt[i] = '0; m_tick[i] = 1'b1; m_clk[i] = ~m_clk[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 1'b0;
                    end
                end else begin
                    m_tick[i] = 1'b0;
                end
                if (wr) m_div[i] = cfg_div;
            end
            if (clear) m_free = '0;
            else if (enable) m_free = m_free + 1;
        end
        x.tick = m_tick;
        x.dclk = m_clk;
        x.free = m_free;
        sb_q.push_back(x);
    endtask

    task automatic drive(input logic we, input logic [2:0] ch, input div_t dv,
                         input logic en, input logic clr);
        cfg_we = we; cfg_ch = ch; cfg_div = dv; enable = en; clear = clr;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; clear = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        model_reset();
        #3;
        n_chk++;
        if (tick !== '0 || div_clk !== '0 || divided_clocks !== '0)
            $display("FAIL reset_state: tick=%b div_clk=%b free=%0d, want all 0", tick, div_clk, divided_clocks);
        else n_pass++;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_reset c%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         c, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
            n_chk++;
            if (tick !== 4'hf || div_clk !== ((c % 2 == 0) ? 4'hf : 4'h0) || divided_clocks !== CW'(c + 1))
                $display("FAIL div0_pattern c%0d: tick=%b div_clk=%b free=%0d, want 1111 %s %0d",
                         c, tick, div_clk, divided_clocks, (c % 2 == 0) ? "1111" : "0000", c + 1);
            else n_pass++;
        end
    endtask

    task automatic test_program();
        int first, npulse, ntog, last, badgap;
        logic prev;
        drive(1'b1, 3'd1, 32'd4, 1'b1, 1'b0);
        e = sb_q.pop_front();
        n_chk++;
        if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
            $display("FAIL sb_prog_wr: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                     tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
        else n_pass++;
        n_chk++;
        if (tick[1] !== 1'b0) $display("FAIL prog_wr_suppress: tick1=%b, want 0", tick[1]);
        else n_pass++;
        first = -1; npulse = 0; ntog = 0; last = 0; badgap = 0; prev = div_clk[1];
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_prog k%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         k, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
            if (tick[1] === 1'b1) begin
                if (first < 0) first = k;
                else if (k - last != 5) badgap++;
                last = k;
                npulse++;
            end
            if (div_clk[1] !== prev) ntog++;
            prev = div_clk[1];
        end
        n_chk++;
        if (first != 5 || npulse != 4 || badgap != 0)
            $display("FAIL prog_tick_period: first=%0d pulses=%0d badgaps=%0d, want 5 4 0", first, npulse, badgap);
        else n_pass++;
        n_chk++;
        if (ntog != 4) $display("FAIL prog_divclk_period: toggles in 20 cycles=%0d, want 4", ntog);
        else n_pass++;
    endtask

    task automatic test_enable_gating();
        logic [NCH-1:0] hold_clk;
        logic [CW-1:0]  hold_free;
        int first;
        for (int c = 0; c < 9; c++) begin
            if (c == 2) begin
                hold_clk  = div_clk;
                hold_free = divided_clocks;
            end
            drive(1'b0, 3'd0, '0, (c < 2), 1'b0);
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_gate c%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         c, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
            if (c >= 2) begin
                n_chk++;
                if (tick !== '0 || div_clk !== hold_clk || divided_clocks !== hold_free)
                    $display("FAIL gate_hold c%0d: tick=%b div_clk=%b free=%0d, want 0000 %b %0d",
                             c, tick, div_clk, divided_clocks, hold_clk, hold_free);
                else n_pass++;
            end
        end
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_resume k%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         k, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
            if (tick[1] === 1'b1 && first < 0) first = k;
        end
        n_chk++;
        if (first + 9 != 12)
            $display("FAIL gate_delay: cycles from last tick to next=%0d, want 12", first + 9);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic lvl;
        int   first;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) lvl = div_clk[2];
            if (c == 0)      drive(1'b1, 3'd2, 32'd2, 1'b1, 1'b0);
            else if (c == 3) drive(1'b1, 3'd2, 32'd3, 1'b1, 1'b0);
            else             drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_coll c%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         c, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
        end
        n_chk++;
        if (tick[2] !== 1'b0 || div_clk[2] !== lvl)
            $display("FAIL coll_write_wins: tick2=%b div_clk2=%b, want 0 %b", tick[2], div_clk[2], lvl);
        else n_pass++;
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_coll_after k%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         k, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
            if (tick[2] === 1'b1 && first < 0) first = k;
        end
        n_chk++;
        if (first != 4) $display("FAIL coll_next_tick: first tick2 after %0d cycles, want 4", first);
        else n_pass++;
    endtask

    task automatic test_illegal_clear();
        int first;
        for (int c = 0; c < 13; c++) begin
            case (c)
                0:       drive(1'b1, 3'd6, 32'd7, 1'b1, 1'b0);
                3:       drive(1'b0, 3'd0, '0, 1'b1, 1'b1);
                9:       drive(1'b1, 3'd3, 32'd1, 1'b0, 1'b1);
                default: drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
            endcase
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_clr c%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         c, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
            if (c == 0) begin
                n_chk++;
                if (tick[0] !== 1'b1 || tick[3] !== 1'b1)
                    $display("FAIL illegal_write: tick0=%b tick3=%b, want 1 1", tick[0], tick[3]);
                else n_pass++;
            end
            if (c == 3 || c == 9) begin
                n_chk++;
                if (tick !== '0 || div_clk !== '0 || divided_clocks !== '0)
                    $display("FAIL clear_outputs c%0d: tick=%b div_clk=%b free=%0d, want all 0",
                             c, tick, div_clk, divided_clocks);
                else n_pass++;
                first = -1;
            end
            if (c > 3 && c < 9 && tick[1] === 1'b1 && first < 0) first = c - 3;
            if (c == 8) begin
                n_chk++;
                if (first != 5) $display("FAIL clear_keeps_div: first tick1=%0d, want 5", first);
                else n_pass++;
            end
            if (c > 9) begin
                n_chk++;
                if (tick[3] !== ((c - 9) % 2 == 0))
                    $display("FAIL clear_with_write c%0d: tick3=%b, want %0d", c, tick[3], (c - 9) % 2 == 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive(1'b1, 3'd0, 32'd9, 1'b1, 1'b0);
            else        drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_pre_arst c%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         c, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (tick !== '0 || div_clk !== '0 || divided_clocks !== '0)
            $display("FAIL arst_immediate: tick=%b div_clk=%b free=%0d, want all 0", tick, div_clk, divided_clocks);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) reset = 1'b1;
            drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_chk++;
            if (tick !== e.tick || div_clk !== e.dclk || divided_clocks !== e.free)
                $display("FAIL sb_arst c%0d: tick=%b div_clk=%b free=%0d, want %b %b %0d",
                         c, tick, div_clk, divided_clocks, e.tick, e.dclk, e.free);
            else n_pass++;
            if (c >= 2) begin
                n_chk++;
                if (tick !== 4'hf || divided_clocks !== CW'(c - 1))
                    $display("FAIL arst_default_div c%0d: tick=%b free=%0d, want 1111 %0d",
                             c, tick, divided_clocks, c - 1);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_program();
        test_enable_gating();
        test_collision();
        test_illegal_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels, range 1..8.
REQ-002 SHALL have parameter CNT_W, default 32: width of the per-channel counter, divide register and free-running counter.
REQ-003 SHALL have parameter DEFAULT_DIV, default 0: divide value loaded into every channel at reset.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: global count enable.
REQ-007 SHALL have port clear, input, 1 bit: synchronous clear of all counters and outputs; divide registers are kept.
REQ-008 SHALL have port cfg_we, input, 1 bit: write strobe for a divide value.
REQ-009 SHALL have port cfg_ch, input, 3 bits: channel index for the write.
REQ-010 SHALL have port cfg_div, input, CNT_W bits: divide value to write.
REQ-011 SHALL have port tick, output, NUM_CH bits: one-cycle enable pulse per channel.
REQ-012 SHALL have port div_clk, output, NUM_CH bits: square-wave divided clock per channel.
REQ-013 SHALL have port divided_clocks, output, CNT_W bits: free-running counter; bit k toggles every 2^k cycles.

Function
REQ-014 SHALL give each channel a divide register div_reg[i] and a counter cnt[i], both CNT_W bits.
REQ-015 SHALL, while enable=1, increment cnt[i] each cycle; when cnt[i]==div_reg[i], reload cnt[i] to 0, set tick[i]=1 for that cycle's registered output, and toggle div_clk[i].
REQ-016 SHALL therefore produce a tick period of div_reg+1 cycles and a div_clk period of 2*(div_reg+1) cycles with 50% duty.
REQ-017 SHALL, for div_reg=0, hold tick[i] high continuously and toggle div_clk[i] every cycle.
REQ-018 SHALL drive tick and div_clk directly from flops, with no combinational path from any input.
REQ-019 SHALL, while enable=0, hold cnt, div_clk and divided_clocks, and drive tick to 0.
REQ-020 SHALL, on cfg_we=1 with cfg_ch<NUM_CH, write cfg_div to div_reg[cfg_ch], zero cnt[cfg_ch], and suppress tick[cfg_ch] that cycle; div_clk[cfg_ch] keeps its level.
REQ-021 SHALL ignore writes with cfg_ch>=NUM_CH and leave all state unchanged.
REQ-022 SHALL let a write win over a simultaneous terminal count on the same channel: no tick and no toggle on that channel.
REQ-023 SHALL, on clear=1, zero every cnt, tick, div_clk and divided_clocks, regardless of enable.
REQ-024 SHALL, when clear and cfg_we are both asserted, apply clear and still update div_reg.
REQ-025 SHALL let divided_clocks wrap from all-ones to 0 without a flag.
REQ-026 SHALL make cnt compare with equality only, so a new div_reg below the current cnt cannot occur (see REQ-020).

Reset
REQ-027 SHALL, on reset=0, immediately set div_reg[i]=DEFAULT_DIV, and cnt[i], tick, div_clk and divided_clocks to 0.
REQ-028 SHALL, when reset is released, begin counting on the first rising edge with enable=1; reset asserted mid-period SHALL abandon that period.

Structure
REQ-029 SHALL place the NUM_CH/CNT_W defaults, MAX_CH=8 and the typedef div_t (logic [CNT_W-1:0]) in package clk_div_pkg.
REQ-030 SHALL implement one channel as sub-module div_channel (counter, divide register, tick, div_clk), instantiated NUM_CH times via generate.

Verification
REQ-031 Reset: NUM_CH=4, DEFAULT_DIV=0, enable=1 -> tick=4'b1111 every cycle; div_clk toggles every cycle; divided_clocks counts 0,1,2,...
REQ-032 Programming: write cfg_ch=1, cfg_div=4 -> tick[1] pulses every 5 cycles, first pulse 5 cycles after the write; div_clk[1] period is 10 cycles.
REQ-033 Enable gating: enable=0 for 7 cycles mid-period -> tick=0 throughout; cnt and div_clk resume unchanged; the next tick is delayed by exactly 7 cycles.
REQ-034 Collision: write cfg_ch=2, cfg_div=3 on the cycle channel 2 reaches terminal count -> no tick and no div_clk toggle that cycle; the next tick comes 4 cycles later.
REQ-035 Illegal and clear: write cfg_ch=6 with NUM_CH=4 -> no state change; clear=1 for one cycle -> all outputs 0 the next cycle, div_reg values kept.
REQ-036 Async reset: assert reset=0 between clock edges with div_reg=9 -> outputs go to 0 immediately; after release, div_reg=DEFAULT_DIV.
